// File: rtl/dac_seq_master.sv
// DAC sequence initiator: steps a 14-bit code through a programmed ramp and
// hands each point to the DAC driver over a req/ack level handshake.
module dac_seq_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [13:0] reg_start_val,
  input  logic [13:0] reg_step,
  input  logic [15:0] reg_point_num,
  input  logic [31:0] reg_interval,
  input  logic [31:0] reg_timeout,
  input  logic        reg_loop,
  input  logic        dac_ack,
  output logic        dac_req,
  output logic [13:0] dac_val,
  output logic        ack_clr,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic [15:0] point_idx
);

  typedef enum logic [2:0] {IDLE, PRE_CLR, WAIT_ACK, ACK_CLR, GAP} state_t;

  state_t      state, state_nx;
  logic [13:0] c_start, c_step, val_nx;
  logic [15:0] c_last, idx_nx;
  logic [31:0] c_gap, c_to, cnt, cnt_nx;
  logic        c_loop, stop_seen, stop_nx, to_hit, to_nx, err_nx, done_nx, cfg_ld;

  always_comb begin
    state_nx = state;
    val_nx   = dac_val;
    idx_nx   = point_idx;
    cnt_nx   = cnt;
    stop_nx  = stop_seen | stop;
    to_nx    = to_hit;
    err_nx   = err_timeout;
    done_nx  = 1'b0;
    cfg_ld   = 1'b0;
    case (state)
      IDLE: begin
        stop_nx = 1'b0;
        if (start && !stop) begin
          cfg_ld   = 1'b1;
          val_nx   = reg_start_val;
          idx_nx   = '0;
          err_nx   = 1'b0;
          to_nx    = 1'b0;
          state_nx = PRE_CLR;
        end
      end
      PRE_CLR: begin
        cnt_nx   = 32'd1;
        state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        // ack only trusted once req has been up long enough to cross the driver's sync
        if (dac_ack && cnt >= 32'd3) begin
          state_nx = ACK_CLR;
        end else if (c_to != '0 && cnt == c_to) begin
          to_nx    = 1'b1;
          err_nx   = 1'b1;
          state_nx = ACK_CLR;
        end else if (cnt != '1) begin
          cnt_nx = cnt + 32'd1;
        end
      end
      ACK_CLR: begin
        cnt_nx   = 32'd1;
        state_nx = to_hit ? IDLE : GAP;
      end
      GAP: begin
        if (cnt == c_gap) begin
          cnt_nx = 32'd1;
          if (stop_nx) begin
            state_nx = IDLE;
          end else if (point_idx == c_last) begin
            if (c_loop) begin
              val_nx   = c_start;
              idx_nx   = '0;
              state_nx = WAIT_ACK;
            end else begin
              done_nx  = 1'b1;
              state_nx = IDLE;
            end
          end else begin
            val_nx   = dac_val + c_step;
            idx_nx   = point_idx + 16'd1;
            state_nx = WAIT_ACK;
          end
        end else begin
          cnt_nx = cnt + 32'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      stop_seen   <= 1'b0;
      to_hit      <= 1'b0;
      c_start     <= '0;
      c_step      <= '0;
      c_last      <= '0;
      c_gap       <= 32'd2;
      c_to        <= '0;
      c_loop      <= 1'b0;
      dac_req     <= 1'b0;
      dac_val     <= '0;
      ack_clr     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      point_idx   <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      stop_seen   <= stop_nx;
      to_hit      <= to_nx;
      dac_req     <= (state_nx == WAIT_ACK);
      ack_clr     <= (state_nx == PRE_CLR) || (state_nx == ACK_CLR);
      busy        <= (state_nx != IDLE);
      done        <= done_nx;
      err_timeout <= err_nx;
      dac_val     <= val_nx;
      point_idx   <= idx_nx;
      if (cfg_ld) begin
        c_start <= reg_start_val;
        c_step  <= reg_step;
        c_last  <= (reg_point_num == '0) ? 16'd0 : reg_point_num - 16'd1;
        c_gap   <= (reg_interval < 32'd2) ? 32'd2 : reg_interval;
        c_to    <= reg_timeout;
        c_loop  <= reg_loop;
      end
    end
  end

endmodule

// File: tb/tb_dac_seq_master.sv
// Scoreboard bench for dac_seq_master: a behavioural DAC driver acks each
// request and pops the expected code; timing and flags checked alongside.
module tb_dac_seq_master;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, reg_loop, dac_ack;
  logic [13:0] reg_start_val, reg_step;
  logic [15:0] reg_point_num;
  logic [31:0] reg_interval, reg_timeout;
  logic        dac_req, ack_clr, busy, done, err_timeout;
  logic [13:0] dac_val;
  logic [15:0] point_idx;

  dac_seq_master dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .reg_start_val(reg_start_val), .reg_step(reg_step),
    .reg_point_num(reg_point_num), .reg_interval(reg_interval),
    .reg_timeout(reg_timeout), .reg_loop(reg_loop), .dac_ack(dac_ack),
    .dac_req(dac_req), .dac_val(dac_val), .ack_clr(ack_clr), .busy(busy),
    .done(done), .err_timeout(err_timeout), .point_idx(point_idx)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_err = 0;
  int          done_cnt = 0, ack_total = 0, hi = 0, lo = 0;
  int          drv_time = 5, exp_hi = 5, exp_lo = 0, d0;
  bit          ack_en = 1'b1, seen_ack = 1'b0;
  logic [13:0] hold;
  logic [13:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // driver model: ack after drv_time cycles of req, cleared by ack_clr
  task automatic drv();
    if (!rst_n) begin
      dac_ack = 1'b0; hi = 0; lo = 0; seen_ack = 1'b0;
      return;
    end
    if (ack_clr) dac_ack = 1'b0;
    if (done) begin
      done_cnt++;
      chk("done_busy", busy, 0);
    end
    if (dac_req) begin
      if (hi == 0) begin
        if (seen_ack && exp_lo != 0) chk("req_low", lo, exp_lo);
        hold = dac_val;
      end else chk("val_hold", dac_val, hold);
      hi++; lo = 0;
      if (ack_en && hi == drv_time) begin
        dac_ack = 1'b1; ack_total++; seen_ack = 1'b1;
        if (exp_q.size() == 0) chk("extra_code", dac_val, 64'hDEAD);
        else chk("code", dac_val, exp_q.pop_front());
      end
    end else begin
      if (hi != 0) begin
        chk("clr_on_fall", ack_clr, 1);
        if (exp_hi != 0) chk("req_high", hi, exp_hi);
      end
      hi = 0;
      if (busy) lo++;
      else begin lo = 0; seen_ack = 1'b0; end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    drv();
    #2;
  endtask

  task automatic cfg(input logic [13:0] sv, input logic [13:0] st, input logic [15:0] n,
                     input logic [31:0] iv, input logic [31:0] to, input logic lp);
    reg_start_val = sv; reg_step = st; reg_point_num = n;
    reg_interval = iv; reg_timeout = to; reg_loop = lp;
    exp_lo = 1 + ((iv < 2) ? 2 : int'(iv));
  endtask

  task automatic push_seq(input logic [13:0] sv, input logic [13:0] st, input int n);
    logic [13:0] v;
    v = sv;
    for (int i = 0; i < ((n == 0) ? 1 : n); i++) begin
      exp_q.push_back(v);
      v = v + st;
    end
  endtask

  task automatic go();
    tick(); start = 1'b1;
    tick(); start = 1'b0;
    chk("start_clr", {busy, ack_clr, dac_req, err_timeout}, 4'b1100);
    chk("start_val", {point_idx, dac_val}, {16'd0, reg_start_val});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600 && busy; i++) tick();
    chk("idle_wait", busy, 0);
  endtask

  task automatic wait_req(input logic lvl);
    for (int i = 0; i < 200 && dac_req !== lvl; i++) tick();
    chk("req_wait", dac_req, lvl);
  endtask

  task automatic rst_check(input string tag);
    rst_n = 1'b0;
    #1;
    chk(tag, {dac_req, ack_clr, busy, done, err_timeout, dac_val, point_idx}, 0);
    tick(); tick();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; dac_ack = 1'b0;
    cfg(14'd0, 14'd0, 16'd1, 32'd3, 32'd0, 1'b0);
    tick(); tick();
    chk("reset", {dac_req, ack_clr, busy, done, err_timeout, dac_val, point_idx}, 0);
    rst_n = 1'b1;
    tick();

    // basic ramp
    cfg(14'd100, 14'd10, 16'd4, 32'd3, 32'd0, 1'b0);
    push_seq(14'd100, 14'd10, 4);
    d0 = done_cnt;
    go(); wait_idle();
    chk("ramp_done", done_cnt - d0, 1);
    chk("ramp_q", exp_q.size(), 0);

    // negative step wraps
    cfg(14'd5, 14'h3FFE, 16'd4, 32'd3, 32'd0, 1'b0);
    push_seq(14'd5, 14'h3FFE, 4);
    d0 = done_cnt;
    go(); wait_idle();
    chk("wrap_done", done_cnt - d0, 1);
    chk("wrap_q", exp_q.size(), 0);

    // point_num 0 -> single point, interval 0 -> gap 2
    cfg(14'd42, 14'd1, 16'd0, 32'd0, 32'd0, 1'b0);
    push_seq(14'd42, 14'd1, 0);
    d0 = done_cnt;
    go(); wait_idle();
    chk("one_done", done_cnt - d0, 1);
    chk("one_q", exp_q.size(), 0);

    // loop, stop during third point's WAIT_ACK
    cfg(14'd7, 14'd1, 16'd2, 32'd3, 32'd0, 1'b1);
    exp_q.push_back(14'd7); exp_q.push_back(14'd8); exp_q.push_back(14'd7);
    d0 = done_cnt;
    go();
    for (int i = 0; i < 200 && ack_total < 0; i++) tick();
    wait_req(1); wait_req(0); wait_req(1); wait_req(0); wait_req(1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_busy", {busy, dac_req}, 2'b11);
    wait_idle();
    chk("stop_nodone", done_cnt - d0, 0);
    chk("stop_q", exp_q.size(), 0);

    // timeout, no ack from driver
    ack_en = 1'b0; exp_hi = 20;
    cfg(14'd200, 14'd1, 16'd1, 32'd3, 32'd20, 1'b0);
    d0 = done_cnt;
    go(); wait_req(1); wait_req(0);
    chk("to_clr", {ack_clr, err_timeout, busy}, 3'b111);
    tick();
    chk("to_idle", {ack_clr, err_timeout, busy}, 3'b010);
    chk("to_nodone", done_cnt - d0, 0);

    // next start clears err_timeout
    ack_en = 1'b1; exp_hi = 5;
    cfg(14'd300, 14'd1, 16'd1, 32'd3, 32'd0, 1'b0);
    push_seq(14'd300, 14'd1, 1);
    go(); wait_idle();
    chk("err_kept_clear", err_timeout, 0);
    chk("err_q", exp_q.size(), 0);

    // stale ack before start, driver acks immediately: req must still last 3 cycles
    drv_time = 1; exp_hi = 3;
    cfg(14'd1000, 14'd1, 16'd2, 32'd3, 32'd0, 1'b0);
    push_seq(14'd1000, 14'd1, 2);
    dac_ack = 1'b1;
    go(); wait_idle();
    chk("stale_q", exp_q.size(), 0);
    drv_time = 5; exp_hi = 5;

    // reset mid-GAP
    cfg(14'd100, 14'd10, 16'd4, 32'd3, 32'd0, 1'b0);
    push_seq(14'd100, 14'd10, 4);
    go(); wait_req(1); wait_req(0);
    tick(); tick();
    rst_check("rst_gap");
    tick();

    // reset mid-WAIT_ACK
    push_seq(14'd100, 14'd10, 4);
    go(); wait_req(1); tick();
    rst_check("rst_wait");
    tick();

    // start with stop in IDLE is ignored
    start = 1'b1; stop = 1'b1;
    tick(); start = 1'b0; stop = 1'b0;
    chk("startstop", {busy, ack_clr}, 2'b00);
    tick();
    chk("startstop2", {busy, dac_req}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
